// File: rtl/rocc_cmd_adapter.sv
// RoCC command adapter: decodes a command into an accelerator request and pairs each result with its rd tag.
// Latency: 1 cycle from cmd accept to request valid, and 1 cycle from accelerator result to response valid.
// Backpressure: val/rdy on every channel; a full tag FIFO stalls only xd=1 commands, and a held response stalls results.
module rocc_cmd_adapter #(
    parameter int p_rs1bits      = 32,
    parameter int p_rs2bits      = 32,
    parameter int p_rd_data_bits = 32,
    parameter int p_num_tags     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_val,
    output logic                                  cmd_rdy,
    input  logic [p_rs2bits+p_rs1bits+32-1:0]     cmd_msg,
    output logic                                  req_val,
    input  logic                                  req_rdy,
    output logic [p_rs1bits-1:0]                  req_rs1,
    output logic [p_rs2bits-1:0]                  req_rs2,
    output logic [6:0]                            req_funct,
    output logic                                  req_xd,
    input  logic                                  accel_resp_val,
    output logic                                  accel_resp_rdy,
    input  logic [p_rd_data_bits-1:0]             accel_resp_data,
    output logic                                  resp_val,
    input  logic                                  resp_rdy,
    output logic [5+p_rd_data_bits-1:0]           resp_msg,
    output logic                                  busy,
    output logic [$clog2(p_num_tags+1)-1:0]       num_outstanding
);
    localparam int MW = p_rs2bits + p_rs1bits + 32;
    localparam int CW = $clog2(p_num_tags + 1);
    localparam int AW = $clog2(p_num_tags);

    typedef struct packed {
        logic [p_rs2bits-1:0] rs2;
        logic [p_rs1bits-1:0] rs1;
        logic [6:0]           funct;
        logic                 xd;
        logic [4:0]           rd;
    } cmd_t;

    typedef struct packed {
        logic [4:0]                rd;
        logic [p_rd_data_bits-1:0] data;
    } resp_t;

    cmd_t            cmd_d;
    cmd_t            cmd_q;
    resp_t           resp_q;
    logic            cmd_full;
    logic            resp_full;
    logic [4:0]      tag_mem [p_num_tags];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   tag_count;

    logic            cmd_fire;
    logic            req_fire;
    logic            tag_push;
    logic            tag_pop;
    logic            tag_space;

    always_comb begin
        cmd_d.rs2   = cmd_msg[MW-1 -: p_rs2bits];
        cmd_d.rs1   = cmd_msg[p_rs1bits+31 -: p_rs1bits];
        cmd_d.funct = cmd_msg[31:25];
        cmd_d.xd    = cmd_msg[14];
        cmd_d.rd    = cmd_msg[11:7];
    end

    // rs1/rs2 register indices and the opcode carry no meaning for the accelerator
    logic unused_inst;
    assign unused_inst = ^{cmd_msg[24:15], cmd_msg[13:12], cmd_msg[6:0]};

    assign tag_space = tag_count < CW'(p_num_tags);
    assign req_val   = cmd_full && (!cmd_q.xd || tag_space);
    assign req_fire  = req_val && req_rdy;
    assign cmd_rdy   = !cmd_full || req_fire;
    assign cmd_fire  = cmd_val && cmd_rdy;
    assign tag_push  = req_fire && cmd_q.xd;

    assign accel_resp_rdy = (tag_count != '0) && (!resp_full || resp_rdy);
    assign tag_pop        = accel_resp_val && accel_resp_rdy;

    assign req_rs1   = cmd_q.rs1;
    assign req_rs2   = cmd_q.rs2;
    assign req_funct = cmd_q.funct;
    assign req_xd    = cmd_q.xd;

    assign resp_val        = resp_full;
    assign resp_msg        = resp_q;
    assign busy            = cmd_full || (tag_count != '0) || resp_full;
    assign num_outstanding = tag_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_full  <= 1'b0;
            resp_full <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
        end else begin
            if (cmd_fire)
                cmd_full <= 1'b1;
            else if (req_fire)
                cmd_full <= 1'b0;

            // a result landing in the drain cycle keeps the register occupied
            if (tag_pop)
                resp_full <= 1'b1;
            else if (resp_rdy)
                resp_full <= 1'b0;

            if (tag_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (tag_pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CW'(1);
                2'b01:   tag_count <= tag_count - CW'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_fire)
            cmd_q <= cmd_d;
        if (tag_push)
            tag_mem[wr_ptr] <= cmd_q.rd;
        if (tag_pop) begin
            resp_q.rd   <= tag_mem[rd_ptr];
            resp_q.data <= accel_resp_data;
        end
    end
endmodule

// File: tb/tb_rocc_cmd_adapter.sv
// Scoreboard bench for rocc_cmd_adapter: expected requests and rd tags are queued as commands are
// driven, result data is queued when the accelerator handshake completes, and responses are matched in order.
module tb_rocc_cmd_adapter;
    logic        clk;
    logic        reset;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [95:0] cmd_msg;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [6:0]  req_funct;
    logic        req_xd;
    logic        accel_resp_val;
    logic        accel_resp_rdy;
    logic [31:0] accel_resp_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [36:0] resp_msg;
    logic        busy;
    logic [2:0]  num_outstanding;

    rocc_cmd_adapter dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_val         (cmd_val),
        .cmd_rdy         (cmd_rdy),
        .cmd_msg         (cmd_msg),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_funct       (req_funct),
        .req_xd          (req_xd),
        .accel_resp_val  (accel_resp_val),
        .accel_resp_rdy  (accel_resp_rdy),
        .accel_resp_data (accel_resp_data),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg        (resp_msg),
        .busy            (busy),
        .num_outstanding (num_outstanding)
    );

    typedef struct packed {
        logic [31:0] rs2;
        logic [31:0] rs1;
        logic [6:0]  funct;
        logic        xd;
    } exp_req_t;

    exp_req_t    req_q[$];
    logic [4:0]  rd_q[$];
    logic [31:0] data_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit rand_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after the edge; comb outputs are read 2ns after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_en) begin
            req_rdy         = 1'($urandom_range(0, 1));
            resp_rdy        = 1'($urandom_range(0, 1));
            accel_resp_data = $urandom;
        end
        #1;
    endtask

    function automatic logic [95:0] make_msg(input logic [31:0] rs2, input logic [31:0] rs1,
                                             input logic [6:0] funct, input logic xd,
                                             input logic [4:0] rd);
        logic [31:0] inst;
        inst        = $urandom;
        inst[31:25] = funct;
        inst[14]    = xd;
        inst[11:7]  = rd;
        return {rs2, rs1, inst};
    endfunction

    task automatic push_cmd(input logic [31:0] rs2, input logic [31:0] rs1,
                            input logic [6:0] funct, input logic xd, input logic [4:0] rd);
        exp_req_t e;
        e.rs2   = rs2;
        e.rs1   = rs1;
        e.funct = funct;
        e.xd    = xd;
        req_q.push_back(e);
        if (xd)
            rd_q.push_back(rd);
        cmd_msg = make_msg(rs2, rs1, funct, xd, rd);
        cmd_val = 1'b1;
    endtask

    task automatic wait_cmd_accept();
        bit done;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            #1;
            if (cmd_rdy)
                done = 1;
            step();
        end
        cmd_val = 1'b0;
        if (!done)
            check("cmd_accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_cmd(input logic [31:0] rs2, input logic [31:0] rs1,
                            input logic [6:0] funct, input logic xd, input logic [4:0] rd);
        push_cmd(rs2, rs1, funct, xd, rd);
        wait_cmd_accept();
    endtask

    task automatic drain();
        int n;
        req_rdy        = 1'b1;
        resp_rdy       = 1'b1;
        accel_resp_val = 1'b1;
        n = 0;
        while ((rd_q.size() != 0 || req_q.size() != 0) && n < 1000) begin
            accel_resp_data = $urandom;
            step();
            n++;
        end
        accel_resp_val = 1'b0;
        req_rdy        = 1'b1;
        resp_rdy       = 1'b1;
        check("drain_left", 64'(rd_q.size() + req_q.size()), 64'd0);
        step();
        step();
        check("drain_busy", busy, 1'b0);
    endtask

    // Scoreboard monitor: handshakes sampled mid-cycle are the ones the next edge commits.
    logic [36:0] hold_msg;
    bit          hold_v = 0;
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("resp_hold_val", resp_val, 1'b1);
                check("resp_hold_msg", resp_msg, hold_msg);
            end
            hold_v   = resp_val && !resp_rdy;
            hold_msg = resp_msg;
            check("count_max", num_outstanding <= 3'd4, 1'b1);
            if (req_val && req_rdy) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_req_t e;
                    e = req_q.pop_front();
                    check("req_fields", {req_rs2, req_rs1, req_funct, req_xd}, e);
                end
            end
            if (accel_resp_val && accel_resp_rdy)
                data_q.push_back(accel_resp_data);
            if (resp_val && resp_rdy) begin
                if (rd_q.size() == 0 || data_q.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [36:0] exp_msg;
                    exp_msg = {rd_q.pop_front(), data_q.pop_front()};
                    check("resp_msg", resp_msg, exp_msg);
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        cmd_val         = 1'b0;
        cmd_msg         = '0;
        req_rdy         = 1'b0;
        accel_resp_val  = 1'b0;
        accel_resp_data = '0;
        resp_rdy        = 1'b0;
        repeat (3) step();
        check("rst_cmd_rdy", cmd_rdy, 1'b1);
        check("rst_req_val", req_val, 1'b0);
        check("rst_accel_rdy", accel_resp_rdy, 1'b0);
        check("rst_resp_val", resp_val, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", num_outstanding, 3'd0);
        reset    = 1'b0;
        req_rdy  = 1'b1;
        resp_rdy = 1'b1;
        step();

        // single xd=1 command end to end
        check("idle_req_val", req_val, 1'b0);
        send_cmd(32'h22, 32'h11, 7'd5, 1'b1, 5'd7);
        check("lat_req_val", req_val, 1'b1);
        check("lat_req_rs1", req_rs1, 32'h11);
        check("lat_req_rs2", req_rs2, 32'h22);
        check("lat_req_funct", req_funct, 7'd5);
        check("lat_req_xd", req_xd, 1'b1);
        step();
        check("one_count", num_outstanding, 3'd1);
        check("one_busy", busy, 1'b1);
        check("one_resp_val_pre", resp_val, 1'b0);
        accel_resp_val  = 1'b1;
        accel_resp_data = 32'hABCD;
        step();
        accel_resp_val = 1'b0;
        check("one_resp_val", resp_val, 1'b1);
        check("one_resp_msg", resp_msg, {5'd7, 32'hABCD});
        step();
        check("one_resp_done", resp_val, 1'b0);
        check("one_busy_done", busy, 1'b0);

        // xd=0 command never produces a response
        send_cmd(32'h5, 32'h6, 7'd3, 1'b0, 5'd9);
        step();
        check("nox_count", num_outstanding, 3'd0);
        repeat (3) step();
        check("nox_resp_val", resp_val, 1'b0);
        check("nox_busy", busy, 1'b0);

        // tag FIFO full stalls xd=1 and the xd=0 command queued behind it
        for (int i = 1; i <= 4; i++)
            send_cmd($urandom, $urandom, 7'(i), 1'b1, 5'(i));
        send_cmd(32'h55, 32'h50, 7'd5, 1'b1, 5'd5);
        repeat (2) step();
        check("full_count", num_outstanding, 3'd4);
        check("full_req_val", req_val, 1'b0);
        check("full_cmd_rdy", cmd_rdy, 1'b0);
        push_cmd(32'h66, 32'h60, 7'd6, 1'b0, 5'd6);
        repeat (3) step();
        check("full_cmd_wait", cmd_rdy, 1'b0);
        accel_resp_val  = 1'b1;
        accel_resp_data = 32'h1234;
        step();
        accel_resp_val = 1'b0;
        check("full_resp_rd", resp_msg[36:32], 5'd1);
        check("full_after_count", num_outstanding, 3'd3);
        check("full_req_resume", req_val, 1'b1);
        wait_cmd_accept();
        drain();

        // response back-pressure holds message and blocks results
        resp_rdy = 1'b0;
        send_cmd($urandom, $urandom, 7'd1, 1'b1, 5'd1);
        send_cmd($urandom, $urandom, 7'd2, 1'b1, 5'd2);
        step();
        check("bp_count", num_outstanding, 3'd2);
        accel_resp_val  = 1'b1;
        accel_resp_data = 32'hD1D1_0001;
        step();
        accel_resp_data = 32'hD2D2_0002;
        check("bp_accel_rdy", accel_resp_rdy, 1'b0);
        check("bp_msg", resp_msg, {5'd1, 32'hD1D1_0001});
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_msg", resp_msg, {5'd1, 32'hD1D1_0001});
            check("bp_hold_rdy", accel_resp_rdy, 1'b0);
        end
        resp_rdy = 1'b1;
        step();
        accel_resp_val = 1'b0;
        check("bp_second_msg", resp_msg, {5'd2, 32'hD2D2_0002});
        drain();

        // pointer wrap with random handshakes and results every cycle
        rand_en        = 1;
        accel_resp_val = 1'b1;
        for (int i = 0; i < 20; i++)
            send_cmd($urandom, $urandom, 7'($urandom), 1'b1, 5'(i % 32));
        drain();
        rand_en = 0;
        req_rdy  = 1'b1;
        resp_rdy = 1'b1;

        // reset mid-operation discards tags and the held response
        resp_rdy = 1'b0;
        for (int i = 10; i < 14; i++)
            send_cmd($urandom, $urandom, 7'd0, 1'b1, 5'(i));
        repeat (2) step();
        accel_resp_val  = 1'b1;
        accel_resp_data = 32'hBEEF;
        step();
        accel_resp_val = 1'b0;
        check("pre_rst_count", num_outstanding, 3'd3);
        check("pre_rst_resp_val", resp_val, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rst_count", num_outstanding, 3'd0);
        check("mid_rst_resp_val", resp_val, 1'b0);
        check("mid_rst_cmd_rdy", cmd_rdy, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req_val", req_val, 1'b0);
        check("mid_rst_accel_rdy", accel_resp_rdy, 1'b0);
        req_q.delete();
        rd_q.delete();
        data_q.delete();
        reset    = 1'b0;
        resp_rdy = 1'b1;
        step();
        send_cmd(32'h99, 32'h98, 7'd9, 1'b1, 5'd9);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
